// File: rtl/blob_mover.sv
// rtl/blob_mover.sv - frame-rate sprite position generator with edge bounce
//
// Moves a WIDTH x HEIGHT sprite once per frame on the vsync falling edge by a
// programmable speed. The sprite reflects off the edges of the visible raster.
// The FSM runs WAIT -> UPD_X -> UPD_Y -> WAIT, so a tick in cycle N gives x
// from N+2 and gives y and frame_done from N+3.
//
// Optional feature macro: BLOB_GRAVITY_EN
//   When defined, vertical motion uses an internal signed velocity vy. vy
//   accelerates by one per frame up to 15 and reflects at the floor and the
//   ceiling. When undefined, vertical motion follows the horizontal rules.
//
// Ports:
//   vclock      in   pixel clock, rising-edge logic
//   reset_n     in   asynchronous active-low reset
//   vsync       in   active-low vsync, synchronous to vclock
//   pause       in   1 = skip frames, with no motion
//   speed[3:0]  in   pixels per frame on each axis
//   x[10:0]     out  sprite left edge
//   y[9:0]      out  sprite top edge
//   bounce_x    out  one-cycle pulse on an x reflection
//   bounce_y    out  one-cycle pulse on a y reflection
//   frame_done  out  one-cycle pulse when the y update completes

module blob_mover #(
    parameter int WIDTH    = 16,
    parameter int HEIGHT   = 16,
    parameter int SCREEN_W = 1024,
    parameter int SCREEN_H = 768,
    parameter int X0       = 512,
    parameter int Y0       = 384
) (
    input  logic        vclock,
    input  logic        reset_n,
    input  logic        vsync,
    input  logic        pause,
    input  logic [3:0]  speed,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        bounce_x,
    output logic        bounce_y,
    output logic        frame_done
);

    localparam logic [11:0] X_LIMIT = 12'(SCREEN_W);
    localparam logic [11:0] X_SIZE  = 12'(WIDTH);
    localparam logic [10:0] X_EDGE  = 11'(SCREEN_W - WIDTH);
    localparam logic [10:0] X_RST   = 11'(X0);
    localparam logic [9:0]  Y_EDGE  = 10'(SCREEN_H - HEIGHT);
    localparam logic [9:0]  Y_RST   = 10'(Y0);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_UPD_X = 2'd1,
        S_UPD_Y = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        vsync_dly_q, vsync_dly_d;
    logic [3:0]  spd_q, spd_d;
    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        dir_x_q, dir_x_d;          // 1 = moving right
    logic        bounce_x_q, bounce_x_d;
    logic        bounce_y_q, bounce_y_d;
    logic        frame_done_q, frame_done_d;
    logic        tick;
    logic [11:0] x_wide;
    logic [11:0] spd_wide;

`ifdef BLOB_GRAVITY_EN
    localparam logic signed [12:0] GY_LIMIT = 13'(SCREEN_H);
    localparam logic signed [12:0] GY_SIZE  = 13'(HEIGHT);

    logic signed [6:0]  vy_q, vy_d;
    logic signed [6:0]  vy_inc;
    logic signed [12:0] y_sum;

    // Velocity saturates at +15. y_sum holds the proposed position with the
    // new velocity, and is negative when the sprite would cross the ceiling.
    assign vy_inc = (vy_q >= 7'sd15) ? 7'sd15 : vy_q + 7'sd1;
    assign y_sum  = $signed({3'b000, y_q}) + $signed({{6{vy_inc[6]}}, vy_inc});
`else
    localparam logic [11:0] Y_LIMIT = 12'(SCREEN_H);
    localparam logic [11:0] Y_SIZE  = 12'(HEIGHT);

    logic        dir_y_q, dir_y_d;          // 1 = moving down
    logic [11:0] y_wide;

    assign y_wide = 12'(y_q);
`endif

    assign tick     = vsync_dly_q & ~vsync;
    assign x_wide   = 12'(x_q);
    assign spd_wide = 12'(spd_q);

    always_comb begin
        state_d      = state_q;
        vsync_dly_d  = vsync;
        spd_d        = spd_q;
        x_d          = x_q;
        y_d          = y_q;
        dir_x_d      = dir_x_q;
        bounce_x_d   = 1'b0;
        bounce_y_d   = 1'b0;
        frame_done_d = 1'b0;
`ifdef BLOB_GRAVITY_EN
        vy_d         = vy_q;
`else
        dir_y_d      = dir_y_q;
`endif
        case (state_q)
            S_WAIT: begin
                // pause only gates frame starts, so an update in flight completes.
                if (tick && !pause) begin
                    spd_d   = speed;
                    state_d = S_UPD_X;
                end
            end
            S_UPD_X: begin
                if (dir_x_q) begin
                    if (x_wide + spd_wide + X_SIZE >= X_LIMIT) begin
                        x_d        = X_EDGE;
                        dir_x_d    = 1'b0;
                        bounce_x_d = 1'b1;
                    end else begin
                        x_d = x_q + 11'(spd_q);
                    end
                end else if (x_wide < spd_wide) begin
                    x_d        = '0;
                    dir_x_d    = 1'b1;
                    bounce_x_d = 1'b1;
                end else begin
                    x_d = x_q - 11'(spd_q);
                end
                state_d = S_UPD_Y;
            end
            S_UPD_Y: begin
`ifdef BLOB_GRAVITY_EN
                if (y_sum[12]) begin
                    y_d        = '0;
                    vy_d       = -vy_inc;
                    bounce_y_d = 1'b1;
                end else if (y_sum + GY_SIZE >= GY_LIMIT) begin
                    y_d        = Y_EDGE;
                    vy_d       = -vy_inc;
                    bounce_y_d = 1'b1;
                end else begin
                    y_d  = y_sum[9:0];
                    vy_d = vy_inc;
                end
`else
                if (dir_y_q) begin
                    if (y_wide + spd_wide + Y_SIZE >= Y_LIMIT) begin
                        y_d        = Y_EDGE;
                        dir_y_d    = 1'b0;
                        bounce_y_d = 1'b1;
                    end else begin
                        y_d = y_q + 10'(spd_q);
                    end
                end else if (y_wide < spd_wide) begin
                    y_d        = '0;
                    dir_y_d    = 1'b1;
                    bounce_y_d = 1'b1;
                end else begin
                    y_d = y_q - 10'(spd_q);
                end
`endif
                frame_done_d = 1'b1;
                state_d      = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    // vsync_dly resets low, so a vsync that is already low at release does not
    // produce a tick.
    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_WAIT;
            vsync_dly_q  <= 1'b0;
            spd_q        <= '0;
            x_q          <= X_RST;
            y_q          <= Y_RST;
            dir_x_q      <= 1'b1;
            bounce_x_q   <= 1'b0;
            bounce_y_q   <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef BLOB_GRAVITY_EN
            vy_q         <= '0;
`else
            dir_y_q      <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            vsync_dly_q  <= vsync_dly_d;
            spd_q        <= spd_d;
            x_q          <= x_d;
            y_q          <= y_d;
            dir_x_q      <= dir_x_d;
            bounce_x_q   <= bounce_x_d;
            bounce_y_q   <= bounce_y_d;
            frame_done_q <= frame_done_d;
`ifdef BLOB_GRAVITY_EN
            vy_q         <= vy_d;
`else
            dir_y_q      <= dir_y_d;
`endif
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign bounce_x   = bounce_x_q;
    assign bounce_y   = bounce_y_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_blob_mover.sv
// tb/tb_blob_mover.sv - directed-vector bench for blob_mover

module tb_blob_mover;

    logic        vclock = 1'b0;
    logic        rst_a, rst_b;
    logic        vsync_a, vsync_b;
    logic        pause_a, pause_b;
    logic [3:0]  speed_a, speed_b;
    logic [10:0] x_a, x_b;
    logic [9:0]  y_a, y_b;
    logic        bx_a, bx_b, by_a, by_b, fd_a, fd_b;

    int checks   = 0;
    int failures = 0;

    always #5 vclock = ~vclock;

    blob_mover dut_a (
        .vclock(vclock), .reset_n(rst_a), .vsync(vsync_a), .pause(pause_a),
        .speed(speed_a), .x(x_a), .y(y_a), .bounce_x(bx_a), .bounce_y(by_a),
        .frame_done(fd_a)
    );

    blob_mover #(.X0(1000), .Y0(748)) dut_b (
        .vclock(vclock), .reset_n(rst_b), .vsync(vsync_b), .pause(pause_b),
        .speed(speed_b), .x(x_b), .y(y_b), .bounce_x(bx_b), .bounce_y(by_b),
        .frame_done(fd_b)
    );

    typedef struct {
        logic        vs;
        logic        ps;
        logic [3:0]  sp;
        logic [10:0] ex;
        logic [9:0]  ey;
        logic        ebx;
        logic        eby;
        logic        efd;
    } vec_t;

    vec_t tbl[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One full frame on the selected instance. Entered and left on a negedge
    // with vsync high on the selected instance.
    task automatic frame(input bit sel, input string tag, input logic [10:0] ex,
                         input logic [9:0] ey, input logic ebx, input logic eby);
        if (sel) vsync_b = 1'b0; else vsync_a = 1'b0;
        @(negedge vclock);
        @(negedge vclock);
        chk({tag, " x"},      sel ? x_b  : x_a,  ex);
        chk({tag, " bx"},     sel ? bx_b : bx_a, ebx);
        chk({tag, " fd@x"},   sel ? fd_b : fd_a, 1'b0);
        @(negedge vclock);
        chk({tag, " y"},      sel ? y_b  : y_a,  ey);
        chk({tag, " by"},     sel ? by_b : by_a, eby);
        chk({tag, " fd"},     sel ? fd_b : fd_a, 1'b1);
        chk({tag, " bx@y"},   sel ? bx_b : bx_a, 1'b0);
        if (sel) vsync_b = 1'b1; else vsync_a = 1'b1;
        @(negedge vclock);
        chk({tag, " fd end"}, sel ? fd_b : fd_a, 1'b0);
        chk({tag, " by end"}, sel ? by_b : by_a, 1'b0);
        chk({tag, " bx end"}, sel ? bx_b : bx_a, 1'b0);
    endtask

    initial begin
        //            vs  ps  sp   x    y   bx by fd
        tbl[0]  = '{1, 0, 2, 512, 384, 0, 0, 0};
        tbl[1]  = '{0, 0, 2, 512, 384, 0, 0, 0};  // tick
        tbl[2]  = '{0, 0, 0, 514, 384, 0, 0, 0};  // x at N+2
        tbl[3]  = '{0, 0, 0, 514, 386, 0, 0, 1};  // y, frame_done at N+3
        tbl[4]  = '{1, 0, 0, 514, 386, 0, 0, 0};
        tbl[5]  = '{1, 1, 2, 514, 386, 0, 0, 0};  // paused edges
        tbl[6]  = '{0, 1, 2, 514, 386, 0, 0, 0};
        tbl[7]  = '{0, 1, 2, 514, 386, 0, 0, 0};
        tbl[8]  = '{1, 1, 2, 514, 386, 0, 0, 0};
        tbl[9]  = '{0, 1, 2, 514, 386, 0, 0, 0};
        tbl[10] = '{1, 1, 2, 514, 386, 0, 0, 0};
        tbl[11] = '{0, 1, 2, 514, 386, 0, 0, 0};
        tbl[12] = '{1, 1, 2, 514, 386, 0, 0, 0};
        tbl[13] = '{1, 0, 0, 514, 386, 0, 0, 0};  // speed 0 frame
        tbl[14] = '{0, 0, 0, 514, 386, 0, 0, 0};
        tbl[15] = '{0, 0, 0, 514, 386, 0, 0, 0};
        tbl[16] = '{0, 0, 0, 514, 386, 0, 0, 1};
        tbl[17] = '{1, 0, 3, 514, 386, 0, 0, 0};
        tbl[18] = '{0, 0, 3, 514, 386, 0, 0, 0};  // tick, spd=3
        tbl[19] = '{1, 0, 3, 517, 386, 0, 0, 0};
        tbl[20] = '{0, 1, 3, 517, 389, 0, 0, 1};  // edge + pause during UPD_Y ignored
        tbl[21] = '{0, 0, 3, 517, 389, 0, 0, 0};
        tbl[22] = '{0, 0, 3, 517, 389, 0, 0, 0};
        tbl[23] = '{1, 0, 3, 517, 389, 0, 0, 0};

        rst_a = 1'b0; rst_b = 1'b0;
        vsync_a = 1'b1; vsync_b = 1'b1;
        pause_a = 1'b0; pause_b = 1'b0;
        speed_a = 4'd0; speed_b = 4'd4;
        @(negedge vclock);
        @(negedge vclock);
        chk("reset x",  x_a,  11'd512);
        chk("reset y",  y_a,  10'd384);
        chk("reset bx", bx_a, 1'b0);
        chk("reset by", by_a, 1'b0);
        chk("reset fd", fd_a, 1'b0);
        rst_a = 1'b1; rst_b = 1'b1;

        for (int i = 0; i < 24; i++) begin
            vsync_a = tbl[i].vs;
            pause_a = tbl[i].ps;
            speed_a = tbl[i].sp;
            @(negedge vclock);
            chk($sformatf("vec%0d x", i),  x_a,  tbl[i].ex);
`ifndef BLOB_GRAVITY_EN
            chk($sformatf("vec%0d y", i),  y_a,  tbl[i].ey);
            chk($sformatf("vec%0d by", i), by_a, tbl[i].eby);
`endif
            chk($sformatf("vec%0d bx", i), bx_a, tbl[i].ebx);
            chk($sformatf("vec%0d fd", i), fd_a, tbl[i].efd);
        end

        // Reset asserted while dut_a sits in UPD_X.
        vsync_a = 1'b0;
        @(negedge vclock);
        rst_a = 1'b0;
        #1;
        chk("rst mid x", x_a, 11'd512);
        chk("rst mid y", y_a, 10'd384);
        @(negedge vclock);
        rst_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge vclock);
            chk($sformatf("post rst%0d x", i),  x_a,  11'd512);
            chk($sformatf("post rst%0d y", i),  y_a,  10'd384);
            chk($sformatf("post rst%0d fd", i), fd_a, 1'b0);
            chk($sformatf("post rst%0d bx", i), bx_a, 1'b0);
            chk($sformatf("post rst%0d by", i), by_a, 1'b0);
        end

        // Edge bounces: the exact touch 1004+4+16=1024 clamps to 1008.
`ifdef BLOB_GRAVITY_EN
        frame(1'b1, "B f1", 11'd1004, 10'd749, 1'b0, 1'b0);
        frame(1'b1, "B f2", 11'd1008, 10'd751, 1'b1, 1'b0);
        frame(1'b1, "B f3", 11'd1004, 10'd752, 1'b0, 1'b1);

        vsync_a = 1'b1;
        speed_a = 4'd2;
        @(negedge vclock);
        frame(1'b0, "G f1", 11'd514, 10'd385, 1'b0, 1'b0);
        frame(1'b0, "G f2", 11'd516, 10'd387, 1'b0, 1'b0);
        frame(1'b0, "G f3", 11'd518, 10'd390, 1'b0, 1'b0);
`else
        frame(1'b1, "B f1", 11'd1004, 10'd752, 1'b0, 1'b1);
        frame(1'b1, "B f2", 11'd1008, 10'd748, 1'b1, 1'b0);
        frame(1'b1, "B f3", 11'd1004, 10'd744, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
